// File: rtl/vproc_pkg.sv
// vproc_pkg: shared definitions for vector_proc_seq and its lane ALU.
//   - command opcode encoding (OP_LOAD..OP_AND; 6-7 are reserved)
//   - sequencer state enum
//   - lane slicing helper (bit offset of a lane inside a packed vector)
package vproc_pkg;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Lane 0 occupies the least significant LANE_W bits of a vector.
    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/vproc_lane_alu.sv
// vproc_lane_alu: one-lane combinational ALU of vector_proc_seq.
// Configuration macro: VPROC_SAT_EN -- when defined, ADD/SUB saturate to the
// signed range and report it on sat_o; otherwise they wrap and sat_o is 0.
// Ports:
//   op_i   opcode (OP_ADD/OP_SUB/OP_MUL/OP_AND; anything else yields 0)
//   a_i    operand 1
//   b_i    operand 2
//   y_o    result
//   sat_o  result was clamped (only with VPROC_SAT_EN)
module vproc_lane_alu
    import vproc_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [2:0]        op_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] y_o,
    output logic              sat_o
);

    logic [LANE_W-1:0]   sum;
    logic [LANE_W-1:0]   diff;
    logic [2*LANE_W-1:0] prod;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign prod = {{LANE_W{1'b0}}, a_i} * {{LANE_W{1'b0}}, b_i};

`ifdef VPROC_SAT_EN
    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

    // Signed overflow: operands with the given sign relation produce a
    // result whose sign differs from operand 1.
    logic ovf_add;
    logic ovf_sub;
    assign ovf_add = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (sum[LANE_W-1]  != a_i[LANE_W-1]);
    assign ovf_sub = (a_i[LANE_W-1] != b_i[LANE_W-1]) && (diff[LANE_W-1] != a_i[LANE_W-1]);
`endif

    always_comb begin
        y_o   = '0;
        sat_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                y_o = sum;
`ifdef VPROC_SAT_EN
                if (ovf_add) begin
                    y_o   = a_i[LANE_W-1] ? SMIN : SMAX;
                    sat_o = 1'b1;
                end
`endif
            end
            OP_SUB: begin
                y_o = diff;
`ifdef VPROC_SAT_EN
                if (ovf_sub) begin
                    y_o   = a_i[LANE_W-1] ? SMIN : SMAX;
                    sat_o = 1'b1;
                end
`endif
            end
            OP_MUL:  y_o = prod[LANE_W-1:0];
            OP_AND:  y_o = a_i & b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_proc_seq.sv
// vector_proc_seq: command-driven vector processor. NREG vector registers of
// LANES x LANE_W bits, a single-port MEM_DEPTH-word memory shared between the
// host and a burst sequencer, and a lane-parallel ALU.
// Configuration macro: VPROC_SAT_EN -- signed saturating ADD/SUB, with any
// saturated lane flagged on err together with done.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   mem_we          host write strobe, honoured only while idle
//   mem_addr        host address (write and read)
//   mem_wdata       host write data
//   mem_rdata       registered read data (1-cycle latency); while a burst
//                   owns the port it returns the sequencer's word
//   cmd_valid/ready command handshake; a command is taken when both are high
//                   (ready is high exactly in IDLE) and all cmd_* fields are
//                   captured on that cycle
//   cmd_op          0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6-7 reserved
//   cmd_dst         destination register (LOAD target, STORE source)
//   cmd_src1/src2   ALU operands
//   cmd_addr        burst base address
//   done            one-cycle completion pulse
//   err             qualifies done: address wrap, reserved op or saturation
//   dbg_sel/dbg_vec combinational view of one register
module vector_proc_seq
    import vproc_pkg::*;
#(
    parameter  int LANE_W    = 32,
    parameter  int LANES     = 16,
    parameter  int NREG      = 4,
    parameter  int MEM_DEPTH = 512,
    localparam int ADDR_W    = $clog2(MEM_DEPTH),
    localparam int RSEL_W    = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_we,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [LANE_W-1:0]       mem_wdata,
    output logic [LANE_W-1:0]       mem_rdata,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [RSEL_W-1:0]       cmd_dst,
    input  logic [RSEL_W-1:0]       cmd_src1,
    input  logic [RSEL_W-1:0]       cmd_src2,
    input  logic [ADDR_W-1:0]       cmd_addr,
    output logic                    done,
    output logic                    err,
    input  logic [RSEL_W-1:0]       dbg_sel,
    output logic [LANES*LANE_W-1:0] dbg_vec
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD_LAST  = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] CNT_STORE_LAST = CNT_W'(LANES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [RSEL_W-1:0]   dst_q, src1_q, src2_q;
    logic [ADDR_W-1:0]   base_q;
    logic                err_q;
    logic [VEC_W-1:0]    regs_q [NREG];
    logic [LANE_W-1:0]   mem_q  [MEM_DEPTH];
    logic [LANE_W-1:0]   rdata_q;

    logic hs;
    assign hs = cmd_valid & cmd_ready;

    // ---------------- burst address (base + cnt) mod MEM_DEPTH ----------------
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W-1:0] addr_sub;
    logic              addr_wrap;
    logic [ADDR_W-1:0] seq_addr;

    assign addr_sum  = {1'b0, base_q} + (ADDR_W+1)'(cnt_q);
    assign addr_sub  = ADDR_W'(addr_sum - (ADDR_W+1)'(MEM_DEPTH));
    assign addr_wrap = addr_sum >= (ADDR_W+1)'(MEM_DEPTH);
    assign seq_addr  = addr_wrap ? addr_sub : addr_sum[ADDR_W-1:0];

    // ---------------- memory port arbitration ----------------
    // LOAD issues reads in its first LANES cycles; its last cycle only
    // writes back the final lane, so the port is free for the host then.
    logic              load_rd, store_wr, seq_act;
    logic [ADDR_W-1:0] port_addr;
    logic              port_we;
    logic [LANE_W-1:0] port_wdata;

    assign load_rd    = (state_q == S_LOAD) && (cnt_q != CNT_LOAD_LAST);
    assign store_wr   = (state_q == S_STORE);
    assign seq_act    = load_rd | store_wr;
    assign port_addr  = seq_act ? seq_addr : mem_addr;
    assign port_we    = store_wr | ((state_q == S_IDLE) & mem_we);
    assign port_wdata = store_wr ? regs_q[dst_q][lane_lsb(int'(cnt_q), LANE_W) +: LANE_W]
                                 : mem_wdata;

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (port_we) mem_q[port_addr] <= port_wdata;
    end

    // Read happens on every cycle at the port address, giving old data on
    // a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= mem_q[port_addr];
    end

    assign mem_rdata = rdata_q;
    assign dbg_vec   = regs_q[dbg_sel];

    // ---------------- lane ALUs ----------------
    logic [VEC_W-1:0] opa, opb, alu_y;
    logic [LANES-1:0] lane_sat;

    assign opa = regs_q[src1_q];
    assign opb = regs_q[src2_q];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vproc_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .op_i  (op_q),
            .a_i   (opa[g*LANE_W +: LANE_W]),
            .b_i   (opb[g*LANE_W +: LANE_W]),
            .y_o   (alu_y[g*LANE_W +: LANE_W]),
            .sat_o (lane_sat[g])
        );
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    case (cmd_op)
                        OP_LOAD:                        state_d = S_LOAD;
                        OP_STORE:                       state_d = S_STORE;
                        OP_ADD, OP_SUB, OP_MUL, OP_AND: state_d = S_EXEC;
                        default:                        state_d = S_DONE;
                    endcase
                end
            end
            S_LOAD:  if (cnt_q == CNT_LOAD_LAST)  state_d = S_DONE;
            S_STORE: if (cnt_q == CNT_STORE_LAST) state_d = S_DONE;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) & err_q;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            dst_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
            base_q <= '0;
            err_q  <= 1'b0;
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (hs) begin
                        op_q   <= cmd_op;
                        dst_q  <= cmd_dst;
                        src1_q <= cmd_src1;
                        src2_q <= cmd_src2;
                        base_q <= cmd_addr;
                        err_q  <= (cmd_op > OP_AND);
                    end
                end
                S_LOAD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (load_rd && addr_wrap) err_q <= 1'b1;
                    // Data read in the previous cycle lands in lane cnt-1.
                    if (cnt_q != '0)
                        regs_q[dst_q][lane_lsb(int'(cnt_q) - 1, LANE_W) +: LANE_W] <= rdata_q;
                end
                S_STORE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (addr_wrap) err_q <= 1'b1;
                end
                S_EXEC: begin
                    regs_q[dst_q] <= alu_y;
                    if (|lane_sat) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_proc_seq.sv
`timescale 1ns/1ps
module tb_vector_proc_seq;

    localparam int LANE_W    = 32;
    localparam int LANES     = 16;
    localparam int NREG      = 4;
    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;
    localparam int RSEL_W    = 2;
    localparam int VEC_W     = LANES * LANE_W;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [LANE_W-1:0] mem_wdata = '0;
    logic [LANE_W-1:0] mem_rdata;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [RSEL_W-1:0] cmd_dst = '0;
    logic [RSEL_W-1:0] cmd_src1 = '0;
    logic [RSEL_W-1:0] cmd_src2 = '0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic              done;
    logic              err;
    logic [RSEL_W-1:0] dbg_sel = '0;
    logic [VEC_W-1:0]  dbg_vec;

    vector_proc_seq #(
        .LANE_W(LANE_W), .LANES(LANES), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_addr(cmd_addr),
        .done(done), .err(err), .dbg_sel(dbg_sel), .dbg_vec(dbg_vec)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int cmds_sent = 0;

    int                done_due_q[$];
    logic              done_err_q[$];
    int                rd_due_q[$];
    logic [LANE_W-1:0] exp_q[$];

    logic [VEC_W-1:0] m_reg [NREG];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int                due;
        logic              e;
        logic [LANE_W-1:0] x;
        if (rst_n && done) begin
            done_cnt++;
            if (done_due_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
            end else begin
                due = done_due_q.pop_front();
                e   = done_err_q.pop_front();
                check("done_cycle", VEC_W'(cyc), VEC_W'(due));
                check("done_err", VEC_W'(err), VEC_W'(e));
                check("ready_low_with_done", VEC_W'(cmd_ready), '0);
            end
        end
        if (rd_due_q.size() != 0 && rd_due_q[0] == cyc) begin
            void'(rd_due_q.pop_front());
            x = exp_q.pop_front();
            check("host_rdata", VEC_W'(mem_rdata), VEC_W'(x));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [LANE_W-1:0] d);
        @(posedge clk); #1;
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    endtask

    task automatic host_idle();
        @(posedge clk); #1;
        mem_we = 1'b0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic [LANE_W-1:0] exp);
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = a;
        rd_due_q.push_back(cyc + 1);
        exp_q.push_back(exp);
    endtask

    task automatic send_cmd(input logic [2:0] op, input int dst, input int s1, input int s2,
                            input logic [ADDR_W-1:0] base, input int lat, input logic e);
        int k;
        k = 0;
        @(posedge clk); #1;
        while (!cmd_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_ready_timeout: ready=%b required 1", cmd_ready);
        end else begin
            cmd_valid = 1'b1; cmd_op = op;
            cmd_dst = RSEL_W'(dst); cmd_src1 = RSEL_W'(s1); cmd_src2 = RSEL_W'(s2);
            cmd_addr = base;
            done_due_q.push_back(cyc + lat);
            done_err_q.push_back(e);
            cmds_sent++;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            // Fields must have been captured; scramble them.
            cmd_op   = 3'($urandom_range(0, 7));
            cmd_dst  = RSEL_W'($urandom_range(0, NREG-1));
            cmd_src1 = RSEL_W'($urandom_range(0, NREG-1));
            cmd_src2 = RSEL_W'($urandom_range(0, NREG-1));
            cmd_addr = ADDR_W'($urandom_range(0, MEM_DEPTH-1));
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt < cmds_sent && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        if (done_cnt < cmds_sent) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done count %0d required %0d", done_cnt, cmds_sent);
            cmds_sent = done_cnt;
        end
    endtask

    task automatic check_reg(input int idx);
        dbg_sel = RSEL_W'(idx);
        #1;
        check($sformatf("reg_r%0d", idx), dbg_vec, m_reg[idx]);
    endtask

    task automatic check_lane(input string name, input int idx, input int lane, input logic [LANE_W-1:0] exp);
        logic [VEC_W-1:0] v;
        dbg_sel = RSEL_W'(idx);
        #1;
        v = dbg_vec;
        check(name, VEC_W'(v[lane*LANE_W +: LANE_W]), VEC_W'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic sub_err;
        for (int r = 0; r < NREG; r++) m_reg[r] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("reset_ready", VEC_W'(cmd_ready), VEC_W'(1));
        check("reset_done", VEC_W'(done), '0);
        check("reset_err", VEC_W'(err), '0);
        check("reset_rdata", VEC_W'(mem_rdata), '0);
        for (int r = 0; r < NREG; r++) check_reg(r);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Memory images
        for (int i = 0; i < 16; i++) host_write(ADDR_W'(i), LANE_W'(i + 1));
        for (int i = 16; i < 32; i++) host_write(ADDR_W'(i), 32'hAABBCCDD);
        host_write(ADDR_W'(32), 32'h0000_0000);
        host_write(ADDR_W'(33), 32'h8000_0000);
        for (int i = 2; i < 16; i++) host_write(ADDR_W'(32 + i), LANE_W'(i) * 32'h0101_0101);
        for (int i = 48; i < 64; i++) host_write(ADDR_W'(i), 32'h1);
        for (int i = 0; i < 16; i++) host_write(ADDR_W'(64 + i), 32'h100 + LANE_W'(i));
        host_idle();

        // LOAD r0 <- [0..15]
        send_cmd(OP_LOAD, 0, 0, 0, 9'h000, LANES + 2, 1'b0);
        wait_done();
        for (int i = 0; i < LANES; i++) m_reg[0][i*LANE_W +: LANE_W] = LANE_W'(i + 1);
        check_reg(0);
        check_lane("r0_lane15", 0, 15, 32'h10);

        // LOAD r1 <- [16..31]
        send_cmd(OP_LOAD, 1, 0, 0, 9'h010, LANES + 2, 1'b0);
        wait_done();
        for (int i = 0; i < LANES; i++) m_reg[1][i*LANE_W +: LANE_W] = 32'hAABBCCDD;
        check_reg(1);

        // ADD r2 = r0 + r1
        send_cmd(OP_ADD, 2, 0, 1, 9'h000, 2, 1'b0);
        wait_done();
        for (int i = 0; i < LANES; i++)
            m_reg[2][i*LANE_W +: LANE_W] = m_reg[0][i*LANE_W +: LANE_W] + m_reg[1][i*LANE_W +: LANE_W];
        check_reg(2);
        check_lane("add_lane0", 2, 0, 32'hAABBCCDE);

        // MUL r3 = r0 * r0
        send_cmd(OP_MUL, 3, 0, 0, 9'h000, 2, 1'b0);
        wait_done();
        for (int i = 0; i < LANES; i++) m_reg[3][i*LANE_W +: LANE_W] = LANE_W'((i + 1) * (i + 1));
        check_reg(3);
        check_lane("mul_lane15", 3, 15, 32'h100);

        // STORE r2 at 0x1F8: lanes 8..15 wrap to 0x000..0x007
        send_cmd(OP_STORE, 2, 0, 0, 9'h1F8, LANES + 1, 1'b1);
        wait_done();
        host_read(9'h1F8, 32'hAABBCCDE);
        host_read(9'h1FF, 32'hAABBCCE5);
        host_read(9'h000, 32'hAABBCCE6);
        host_read(9'h007, 32'hAABBCCED);
        host_read(9'h008, 32'h0000_0009);

        // SUB r2 = A - B (lane 0: 0-1, lane 1: 0x80000000-1)
        send_cmd(OP_LOAD, 0, 0, 0, 9'h020, LANES + 2, 1'b0);
        wait_done();
        send_cmd(OP_LOAD, 1, 0, 0, 9'h030, LANES + 2, 1'b0);
        wait_done();
        m_reg[0][0 +: LANE_W] = 32'h0;
        m_reg[0][LANE_W +: LANE_W] = 32'h8000_0000;
        for (int i = 2; i < LANES; i++) m_reg[0][i*LANE_W +: LANE_W] = LANE_W'(i) * 32'h0101_0101;
        for (int i = 0; i < LANES; i++) m_reg[1][i*LANE_W +: LANE_W] = 32'h1;
        check_reg(0);
        check_reg(1);
        for (int i = 0; i < LANES; i++)
            m_reg[2][i*LANE_W +: LANE_W] = m_reg[0][i*LANE_W +: LANE_W] - 32'h1;
`ifdef VPROC_SAT_EN
        m_reg[2][LANE_W +: LANE_W] = 32'h8000_0000;
        sub_err = 1'b1;
`else
        sub_err = 1'b0;
`endif
        send_cmd(OP_SUB, 2, 0, 1, 9'h000, 2, sub_err);
        wait_done();
        check_reg(2);
        check_lane("sub_lane0", 2, 0, 32'hFFFF_FFFF);

        // AND r3 = r2 & r1
        send_cmd(OP_AND, 3, 2, 1, 9'h000, 2, 1'b0);
        wait_done();
        m_reg[3] = m_reg[2] & m_reg[1];
        check_reg(3);

        // ADD r0 = r0 + r1 (destination is also an operand)
        send_cmd(OP_ADD, 0, 0, 1, 9'h000, 2, 1'b0);
        wait_done();
        for (int i = 0; i < LANES; i++)
            m_reg[0][i*LANE_W +: LANE_W] = m_reg[0][i*LANE_W +: LANE_W] + 32'h1;
        check_reg(0);

        // Reserved ops: done one cycle later with err, registers untouched
        send_cmd(3'd7, 0, 1, 2, 9'h000, 1, 1'b1);
        wait_done();
        send_cmd(3'd6, 1, 0, 0, 9'h000, 1, 1'b1);
        wait_done();
        for (int r = 0; r < NREG; r++) check_reg(r);

        // Host writes during a LOAD are ignored
        send_cmd(OP_LOAD, 3, 0, 0, 9'h040, LANES + 2, 1'b0);
        host_write(9'h040, 32'hDEADBEEF);
        host_write(9'h041, 32'hDEADBEEF);
        host_idle();
        wait_done();
        for (int i = 0; i < LANES; i++) m_reg[3][i*LANE_W +: LANE_W] = 32'h100 + LANE_W'(i);
        check_reg(3);
        host_read(9'h040, 32'h100);
        host_read(9'h041, 32'h101);

        // Same-address write+read in IDLE returns the old word
        host_write(9'h050, 32'h1111_1111);
        host_idle();
        @(posedge clk); #1;
        mem_we = 1'b1; mem_addr = 9'h050; mem_wdata = 32'h2222_2222;
        rd_due_q.push_back(cyc + 1);
        exp_q.push_back(32'h1111_1111);
        host_idle();
        host_read(9'h050, 32'h2222_2222);

        // Reset at LOAD cycle 5
        send_cmd(OP_LOAD, 0, 0, 0, 9'h040, LANES + 2, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        done_due_q.delete();
        done_err_q.delete();
        cmds_sent = done_cnt;
        for (int r = 0; r < NREG; r++) m_reg[r] = '0;
        check("rst_mid_ready", VEC_W'(cmd_ready), VEC_W'(1));
        check("rst_mid_done", VEC_W'(done), '0);
        for (int r = 0; r < NREG; r++) check_reg(r);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Next LOAD after the aborted one runs normally; memory was kept
        send_cmd(OP_LOAD, 0, 0, 0, 9'h040, LANES + 2, 1'b0);
        wait_done();
        for (int i = 0; i < LANES; i++) m_reg[0][i*LANE_W +: LANE_W] = 32'h100 + LANE_W'(i);
        check_reg(0);
        check_reg(1);
        host_read(9'h1F8, 32'hAABBCCDE);

        // Drain
        repeat (4) @(posedge clk);
        #2;
        check("pending_done", VEC_W'(done_due_q.size()), '0);
        check("pending_reads", VEC_W'(rd_due_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
